// File: rtl/iddmm_mul_pkg.sv
// Shared constants, sideband type and elaboration helpers for the IDDMM multiplier.
// IDDMM_MUL_OUT_REG_EN adds one output register stage, which LAT_OF accounts for.
package iddmm_mul_pkg;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic             low;
        logic [TAG_W-1:0] tag;
    } sideband;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int N_OF(input int width, input int limb);
        return width / limb;
    endfunction

    function automatic int LAT_OF(input int width, input int limb);
`ifdef IDDMM_MUL_OUT_REG_EN
        return 2 + clog2(N_OF(width, limb) * N_OF(width, limb));
`else
        return 1 + clog2(N_OF(width, limb) * N_OF(width, limb));
`endif
    endfunction

    // Number of terms left after k pairwise-add levels.
    function automatic int level_cnt(input int p, input int k);
        int c;
        c = p;
        for (int i = 0; i < k; i++) c = (c + 1) / 2;
        return c;
    endfunction

endpackage

// File: rtl/iddmm_mul_tree_level.sv
// One registered adder-tree level: sums adjacent term pairs, an odd last term passes through.
// Latency 1 cycle; holds all outputs when i_en is low.
module iddmm_mul_tree_level #(
    parameter int CNT = 2,
    parameter int W   = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_en,
    input  logic [CNT-1:0][W-1:0]          i_terms,
    output logic [(CNT+1)/2-1:0][W-1:0]    o_terms
);

    for (genvar m = 0; m < (CNT + 1) / 2; m++) begin : g_pair
        if (2 * m + 1 < CNT) begin : g_add
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    o_terms[m] <= '0;
                else if (i_en) o_terms[m] <= i_terms[2*m] + i_terms[2*m+1];
            end
        end else begin : g_pass
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    o_terms[m] <= '0;
                else if (i_en) o_terms[m] <= i_terms[2*m];
            end
        end
    end

endmodule

// File: rtl/iddmm_mul_pipe.sv
// Stallable pipelined WIDTH x WIDTH multiplier (limb products + registered adder tree), optional low-half mode.
// Latency 1+clog2(N*N) (one more with IDDMM_MUL_OUT_REG_EN); whole pipe freezes while out_valid && !out_ready.
module iddmm_mul_pipe #(
    parameter int WIDTH = 128,
    parameter int LIMB  = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic                 in_low,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]     out_tag
);
    import iddmm_mul_pkg::*;

    localparam int N  = N_OF(WIDTH, LIMB);
    localparam int P  = N * N;
    localparam int D  = clog2(P);
    localparam int W2 = 2 * WIDTH;

    typedef logic [2*LIMB-1:0] pp_t;
    typedef logic [W2-1:0]     dw_t;
    typedef struct packed {
        logic             low;
        logic [TAG_W-1:0] tag;
    } sb_t;

    if ((WIDTH % LIMB) != 0 || LIMB > WIDTH) begin : g_bad_cfg
        $error("iddmm_mul_pipe: WIDTH must be a non-zero multiple of LIMB");
    end

    logic                 w_en;
    pp_t  [P-1:0]         r_pp;
    logic [P-1:0][W2-1:0] w_terms;
    logic [D:0]           r_vld;
    sb_t  [D:0]           r_sb;
    dw_t                  w_final;
    dw_t                  w_masked;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Stage 0: limb products, then each placed at its (i+j)*LIMB weight for the tree.
    for (genvar i = 0; i < N; i++) begin : g_x
        for (genvar j = 0; j < N; j++) begin : g_y
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_pp[i*N+j] <= '0;
                else if (w_en)
                    r_pp[i*N+j] <= pp_t'(in_x[i*LIMB +: LIMB]) * pp_t'(in_y[j*LIMB +: LIMB]);
            end
            assign w_terms[i*N+j] = dw_t'(r_pp[i*N+j]) << ((i + j) * LIMB);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_sb  <= '0;
        end else if (w_en) begin
            r_vld[0] <= in_valid;
            r_sb[0]  <= {in_low, in_tag};
            for (int k = 1; k <= D; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_sb[k]  <= r_sb[k-1];
            end
        end
    end

    for (genvar k = 0; k < D; k++) begin : g_lvl
        localparam int CI = level_cnt(P, k);
        localparam int CO = level_cnt(P, k + 1);
        logic [CI-1:0][W2-1:0] w_in;
        logic [CO-1:0][W2-1:0] w_sum;
        if (k == 0) begin : g_first
            assign w_in = w_terms;
        end else begin : g_next
            assign w_in = g_lvl[k-1].w_sum;
        end
        iddmm_mul_tree_level #(.CNT(CI), .W(W2)) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_en),
            .i_terms (w_in),
            .o_terms (w_sum)
        );
    end

    if (D == 0) begin : g_final_direct
        assign w_final = w_terms[0];
    end else begin : g_final_tree
        assign w_final = g_lvl[D-1].w_sum[0];
    end

    assign w_masked = r_sb[D].low ? {{WIDTH{1'b0}}, w_final[WIDTH-1:0]} : w_final;

`ifdef IDDMM_MUL_OUT_REG_EN
    logic             r_out_vld;
    dw_t              r_out_res;
    logic [TAG_W-1:0] r_out_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_res <= '0;
            r_out_tag <= '0;
        end else if (w_en) begin
            r_out_vld <= r_vld[D];
            r_out_res <= w_masked;
            r_out_tag <= r_sb[D].tag;
        end
    end

    assign out_valid  = r_out_vld;
    assign out_result = r_out_res;
    assign out_tag    = r_out_tag;
`else
    assign out_valid  = r_vld[D];
    assign out_result = w_masked;
    assign out_tag    = r_sb[D].tag;
`endif

endmodule
